// File: rtl/mflop_drain.sv
// mflop_drain: snapshots two parallel words on a capture strobe and drains
// them d1-then-d2 over a valid/ready port, each word tagged with its slot.
//
// Ports:
//   clk       - clock, all state updates on posedge
//   reset     - asynchronous active-high reset
//   cap       - capture strobe
//   d1, d2    - words to capture (size bits each)
//   out_data  - offered word (size bits)
//   out_tag   - 0 = d1 slot, 1 = d2 slot
//   out_valid - out_data/out_tag valid
//   out_ready - consumer accepts; transfer on out_valid & out_ready
//   busy      - captured pair not yet fully drained
//   ovf       - sticky: a capture was dropped
//   ovf_clr   - synchronous clear of ovf (a same-cycle drop wins)
module mflop_drain #(
  parameter int unsigned size = 1
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            cap,
  input  logic [size-1:0] d1,
  input  logic [size-1:0] d2,
  output logic [size-1:0] out_data,
  output logic            out_tag,
  output logic            out_valid,
  input  logic            out_ready,
  output logic            busy,
  output logic            ovf,
  input  logic            ovf_clr
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] SEND1 = 2'd1;
  localparam logic [1:0] SEND2 = 2'd2;

  logic [1:0]      state_q, state_d;
  logic [size-1:0] h1_q, h1_d;
  logic [size-1:0] h2_q, h2_d;
  logic            ovf_d;
  logic [size-1:0] out_data_d;
  logic            out_tag_d;
  logic            out_valid_d;
  logic            xfer;
  logic            drop;

  // State, holding registers and registered outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= IDLE;
      h1_q      <= '0;
      h2_q      <= '0;
      ovf       <= 1'b0;
      out_data  <= '0;
      out_tag   <= 1'b0;
      out_valid <= 1'b0;
      busy      <= 1'b0;
    end else begin
      state_q   <= state_d;
      h1_q      <= h1_d;
      h2_q      <= h2_d;
      ovf       <= ovf_d;
      out_data  <= out_data_d;
      out_tag   <= out_tag_d;
      out_valid <= out_valid_d;
      busy      <= out_valid_d;
    end
  end

  // Next state, capture/drop decisions and next output values.
  always_comb begin
    state_d = state_q;
    h1_d    = h1_q;
    h2_d    = h2_q;
    drop    = 1'b0;
    xfer    = out_valid & out_ready;

    case (state_q)
      IDLE: begin
        if (cap) begin
          h1_d    = d1;
          h2_d    = d2;
          state_d = SEND1;
        end
      end
      SEND1: begin
        drop = cap;
        if (xfer) state_d = SEND2;
      end
      SEND2: begin
        if (xfer) begin
          if (cap) begin
            // Back-to-back capture: reload as the last word leaves.
            h1_d    = d1;
            h2_d    = d2;
            state_d = SEND1;
          end else begin
            state_d = IDLE;
          end
        end else begin
          drop = cap;
        end
      end
      default: state_d = IDLE;
    endcase

    // Set beats clear.
    ovf_d = drop ? 1'b1 : (ovf_clr ? 1'b0 : ovf);

    // Outputs are computed from the next state so they flop alongside it.
    out_valid_d = (state_d != IDLE);
    out_tag_d   = (state_d == SEND2);
    case (state_d)
      SEND1:   out_data_d = h1_d;
      SEND2:   out_data_d = h2_d;
      default: out_data_d = '0;
    endcase
  end

endmodule

// File: tb/tb_mflop_drain.sv
module tb_mflop_drain;

  logic       clk = 1'b0;
  logic       reset;

  logic       cap_a, rdy_a, clr_a, ot_a, ov_a, busy_a, ovf_a;
  logic [3:0] d1_a, d2_a, od_a;

  logic       cap_b, rdy_b, clr_b, ot_b, ov_b, busy_b, ovf_b;
  logic [0:0] d1_b, d2_b, od_b;

  int n_assert = 0;
  int n_fail   = 0;

  logic [7:0] q_a[$];
  logic [7:0] q_b[$];

  always #5 clk = ~clk;

  mflop_drain #(.size(4)) u_a (
    .clk(clk), .reset(reset), .cap(cap_a), .d1(d1_a), .d2(d2_a),
    .out_data(od_a), .out_tag(ot_a), .out_valid(ov_a), .out_ready(rdy_a),
    .busy(busy_a), .ovf(ovf_a), .ovf_clr(clr_a)
  );

  mflop_drain #(.size(1)) u_b (
    .clk(clk), .reset(reset), .cap(cap_b), .d1(d1_b), .d2(d2_b),
    .out_data(od_b), .out_tag(ot_b), .out_valid(ov_b), .out_ready(rdy_b),
    .busy(busy_b), .ovf(ovf_b), .ovf_clr(clr_b)
  );

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Pop the scoreboard for any transfer happening at the coming edge, then advance.
  task automatic tick();
    logic [7:0] e;
    if (ov_a && rdy_a) begin
      if (q_a.size() == 0) chk("sb_a_underflow", {3'b0, ot_a, od_a}, 8'hFF);
      else begin
        e = q_a.pop_front();
        chk("sb_a", {3'b0, ot_a, od_a}, e);
      end
    end
    if (ov_b && rdy_b) begin
      if (q_b.size() == 0) chk("sb_b_underflow", {6'b0, ot_b, od_b}, 8'hFF);
      else begin
        e = q_b.pop_front();
        chk("sb_b", {6'b0, ot_b, od_b}, e);
      end
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset = 1'b1;
    cap_a = 0; rdy_a = 0; clr_a = 0; d1_a = 0; d2_a = 0;
    cap_b = 0; rdy_b = 1; clr_b = 0; d1_b = 0; d2_b = 0;
    #12;
    chk("rst_valid_a", 8'(ov_a), 8'h0);
    chk("rst_busy_a",  8'(busy_a), 8'h0);
    chk("rst_ovf_a",   8'(ovf_a), 8'h0);
    chk("rst_data_a",  8'(od_a), 8'h0);
    chk("rst_tag_a",   8'(ot_a), 8'h0);
    chk("rst_valid_b", 8'(ov_b), 8'h0);
    reset = 1'b0;

    // Basic drain
    cap_a = 1; d1_a = 4'hA; d2_a = 4'h5; rdy_a = 1;
    q_a.push_back(8'h0A); q_a.push_back(8'h15);
    tick();
    cap_a = 0;
    chk("basic_valid1", 8'(ov_a), 8'h1);
    chk("basic_w1", {3'b0, ot_a, od_a}, 8'h0A);
    chk("basic_busy1", 8'(busy_a), 8'h1);
    tick();
    chk("basic_w2", {3'b0, ot_a, od_a}, 8'h15);
    tick();
    chk("basic_valid_end", 8'(ov_a), 8'h0);
    chk("basic_busy_end", 8'(busy_a), 8'h0);
    chk("basic_data_end", 8'(od_a), 8'h0);
    chk("basic_ovf", 8'(ovf_a), 8'h0);

    // Backpressure with changing inputs
    cap_a = 1; d1_a = 4'h3; d2_a = 4'hC; rdy_a = 0;
    q_a.push_back(8'h03); q_a.push_back(8'h1C);
    tick();
    cap_a = 0;
    for (int i = 0; i < 5; i++) begin
      d1_a = 4'($urandom_range(15, 0));
      d2_a = 4'($urandom_range(15, 0));
      chk("bp_hold_valid", 8'(ov_a), 8'h1);
      chk("bp_hold_word", {3'b0, ot_a, od_a}, 8'h03);
      tick();
    end
    rdy_a = 1;
    tick();
    chk("bp_w2", {3'b0, ot_a, od_a}, 8'h1C);
    tick();
    chk("bp_valid_end", 8'(ov_a), 8'h0);

    // Back-to-back
    cap_a = 1; d1_a = 4'h1; d2_a = 4'h2;
    q_a.push_back(8'h01); q_a.push_back(8'h12);
    tick();
    cap_a = 0;
    chk("b2b_valid1", 8'(ov_a), 8'h1);
    tick();
    cap_a = 1; d1_a = 4'h7; d2_a = 4'h8;
    q_a.push_back(8'h07); q_a.push_back(8'h18);
    chk("b2b_valid2", 8'(ov_a), 8'h1);
    chk("b2b_tag2", 8'(ot_a), 8'h1);
    tick();
    cap_a = 0;
    chk("b2b_valid3", 8'(ov_a), 8'h1);
    chk("b2b_w3", {3'b0, ot_a, od_a}, 8'h07);
    tick();
    chk("b2b_valid4", 8'(ov_a), 8'h1);
    tick();
    chk("b2b_valid_end", 8'(ov_a), 8'h0);
    chk("b2b_ovf", 8'(ovf_a), 8'h0);

    // Overflow: drop in SEND1
    cap_a = 1; d1_a = 4'h9; d2_a = 4'h6; rdy_a = 0;
    q_a.push_back(8'h09); q_a.push_back(8'h16);
    tick();
    d1_a = 4'hF; d2_a = 4'hF;
    tick();
    cap_a = 0;
    chk("ovf_set", 8'(ovf_a), 8'h1);
    chk("ovf_h1_kept", 8'(od_a), 8'h09);
    rdy_a = 1;
    tick();
    tick();
    chk("ovf_drain_end", 8'(ov_a), 8'h0);
    chk("ovf_sticky", 8'(ovf_a), 8'h1);
    clr_a = 1;
    tick();
    clr_a = 0;
    chk("ovf_clr", 8'(ovf_a), 8'h0);

    // Overflow: drop in SEND2 without transfer, together with clear
    cap_a = 1; d1_a = 4'h4; d2_a = 4'hB;
    q_a.push_back(8'h04); q_a.push_back(8'h1B);
    tick();
    cap_a = 0;
    tick();
    rdy_a = 0; cap_a = 1; clr_a = 1; d1_a = 4'hE; d2_a = 4'hE;
    tick();
    cap_a = 0; clr_a = 0;
    chk("ovf_set_wins", 8'(ovf_a), 8'h1);
    chk("ovf_h2_kept", {3'b0, ot_a, od_a}, 8'h1B);
    rdy_a = 1;
    tick();
    chk("ovf2_end", 8'(ov_a), 8'h0);
    clr_a = 1;
    tick();
    clr_a = 0;
    chk("ovf_clr2", 8'(ovf_a), 8'h0);

    // Reset mid-drain
    cap_a = 1; d1_a = 4'hE; d2_a = 4'hD;
    q_a.push_back(8'h0E);
    tick();
    cap_a = 0;
    chk("mid_w1", {3'b0, ot_a, od_a}, 8'h0E);
    tick();
    chk("mid_w2_offered", {3'b0, ot_a, od_a}, 8'h1D);
    rdy_a = 0;
    #3 reset = 1'b1;
    #1;
    chk("mid_rst_valid", 8'(ov_a), 8'h0);
    chk("mid_rst_busy",  8'(busy_a), 8'h0);
    chk("mid_rst_data",  8'(od_a), 8'h0);
    chk("mid_rst_tag",   8'(ot_a), 8'h0);
    #1 reset = 1'b0;
    cap_a = 1; d1_a = 4'h1; d2_a = 4'h0; rdy_a = 1;
    q_a.push_back(8'h01); q_a.push_back(8'h10);
    tick();
    cap_a = 0;
    chk("post_rst_w1", {3'b0, ot_a, od_a}, 8'h01);
    tick();
    tick();
    chk("post_rst_end", 8'(ov_a), 8'h0);

    // size = 1
    cap_b = 1; d1_b = 1'b1; d2_b = 1'b0;
    q_b.push_back(8'h01); q_b.push_back(8'h02);
    tick();
    cap_b = 0;
    chk("s1_w1", {6'b0, ot_b, od_b}, 8'h01);
    tick();
    chk("s1_w2", {6'b0, ot_b, od_b}, 8'h02);
    tick();
    chk("s1_end", 8'(ov_b), 8'h0);
    chk("s1_busy", 8'(busy_b), 8'h0);

    chk("sb_a_drained", 8'(q_a.size()), 8'h0);
    chk("sb_b_drained", 8'(q_b.size()), 8'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
